// File: rtl/jtag_dmi_master.sv
// jtag_dmi_master: drives a JTAG TAP to run DMI register scans from a valid/ready request port.
// Each TCK period starts on the clk edge that drives TCK low; TDO is sampled on the edge that drives it high.
module jtag_dmi_master #(
    parameter int DMI_ADDR_BITS = 6,
    parameter int DMI_DATA_BITS = 32,
    parameter int DMI_OP_BITS = 2,
    parameter int IR_BITS = 5,
    parameter logic [IR_BITS-1:0] DMI_IR = 5'h11,
    parameter int TCK_DIV = 4,
    parameter int IDLE_CYCLES = 1,
    parameter int DR_BITS = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [DMI_ADDR_BITS-1:0] req_addr_i,
    input  logic [DMI_DATA_BITS-1:0] req_data_i,
    input  logic [DMI_OP_BITS-1:0]   req_op_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [DMI_ADDR_BITS-1:0] rsp_addr_o,
    output logic [DMI_DATA_BITS-1:0] rsp_data_o,
    output logic [DMI_OP_BITS-1:0]   rsp_op_o,
    output logic                     jtag_TCK,
    output logic                     jtag_TMS,
    output logic                     jtag_TDI,
    input  logic                     jtag_TDO
);
    localparam int MAXB = DR_BITS > IR_BITS ? DR_BITS : IR_BITS;
    localparam int CW = $clog2(MAXB + IDLE_CYCLES + 7);
    localparam int DW = $clog2(TCK_DIV);

    typedef enum logic [3:0] {TLR_SEQ, IDLE, IR_HDR, IR_SHIFT, IR_TAIL, DR_HDR, DR_SHIFT, DR_TAIL, RESP} state_t;

    state_t             state, nst;
    logic [CW-1:0]      cnt, ncnt, len;
    logic [DW-1:0]      div;
    logic               tick, last, ntms, ir_loaded;
    logic [DR_BITS-1:0] sh, cap;
    logic [IR_BITS-1:0] ir_sh;

    // cnt is the period index within the current state; len is that state's period count
    always_comb begin
        len = state == TLR_SEQ ? CW'(6) : state == IR_HDR ? CW'(4) : state == IR_SHIFT ? CW'(IR_BITS) :
              state == IR_TAIL ? CW'(2) : state == DR_HDR ? CW'(3) : state == DR_SHIFT ? CW'(DR_BITS) :
              CW'(2 + IDLE_CYCLES);
        last = cnt == len - CW'(1);
        ncnt = last ? '0 : cnt + CW'(1);
        nst = !last ? state : state == TLR_SEQ ? IDLE : state == IR_HDR ? IR_SHIFT : state == IR_SHIFT ? IR_TAIL :
              state == IR_TAIL ? DR_HDR : state == DR_HDR ? DR_SHIFT : state == DR_SHIFT ? DR_TAIL : RESP;
        ntms = nst == TLR_SEQ ? ncnt != CW'(5) : nst == IR_HDR ? ncnt < CW'(2) :
               nst == IR_SHIFT ? ncnt == CW'(IR_BITS - 1) : nst == DR_SHIFT ? ncnt == CW'(DR_BITS - 1) :
               (nst == IR_TAIL || nst == DR_HDR || nst == DR_TAIL) && ncnt == '0;
        tick = div == DW'(TCK_DIV - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= TLR_SEQ;
            cnt         <= '0;
            div         <= '0;
            jtag_TCK    <= 1'b0;
            jtag_TMS    <= 1'b1;
            jtag_TDI    <= 1'b0;
            req_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_addr_o  <= '0;
            rsp_data_o  <= '0;
            rsp_op_o    <= '0;
            ir_loaded   <= 1'b0;
            sh          <= '0;
            cap         <= '0;
            ir_sh       <= '0;
        end else if (state == IDLE) begin
            if (req_valid_i && req_ready_o) begin
                state       <= ir_loaded ? DR_HDR : IR_HDR;
                cnt         <= '0;
                div         <= '0;
                jtag_TMS    <= 1'b1;
                jtag_TDI    <= 1'b0;
                req_ready_o <= 1'b0;
                sh          <= {req_addr_i, req_data_i, req_op_i};
                ir_sh       <= DMI_IR;
            end
        end else if (state == RESP) begin
            if (rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
                req_ready_o <= 1'b1;
                state       <= IDLE;
            end
        end else begin
            div <= tick ? '0 : div + DW'(1);
            if (tick && !jtag_TCK) begin
                jtag_TCK <= 1'b1;
                if (state == DR_SHIFT) cap <= {jtag_TDO, cap[DR_BITS-1:1]};
            end
            if (tick && jtag_TCK) begin
                jtag_TCK <= 1'b0;
                state    <= nst;
                cnt      <= ncnt;
                jtag_TMS <= ntms;
                jtag_TDI <= nst == IR_SHIFT ? ir_sh[0] : nst == DR_SHIFT ? sh[0] : 1'b0;
                if (nst == IR_SHIFT) ir_sh <= ir_sh >> 1;
                if (nst == DR_SHIFT) sh <= sh >> 1;
                if (state == TLR_SEQ) ir_loaded <= 1'b0;
                if (state == IR_TAIL && last) ir_loaded <= 1'b1;
                if (nst == IDLE) req_ready_o <= 1'b1;
                if (nst == RESP) begin
                    rsp_valid_o <= 1'b1;
                    rsp_addr_o  <= cap[DR_BITS-1 -: DMI_ADDR_BITS];
                    rsp_data_o  <= cap[DMI_OP_BITS +: DMI_DATA_BITS];
                    rsp_op_o    <= cap[DMI_OP_BITS-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_jtag_dmi_master.sv
// tb_jtag_dmi_master: directed bench with a behavioural JTAG TAP target and a response scoreboard.
module tb_jtag_dmi_master;
    typedef struct packed {logic [5:0] a; logic [31:0] d; logic [1:0] o;} rsp_t;
    typedef enum {TLR, RTI, SDS, CDR, SDR, E1D, PD, E2D, UDR, SIS, CIR, SIR, E1I, PI, E2I, UIR} tap_t;

    logic        clk = 0, rst = 0;
    logic        req_valid = 0, req_ready, rsp_valid, rsp_ready = 0;
    logic [5:0]  req_addr = 0, rsp_addr;
    logic [31:0] req_data = 0, rsp_data;
    logic [1:0]  req_op = 0, rsp_op;
    logic        jtag_TCK, jtag_TMS, jtag_TDI, jtag_TDO = 0;

    int errors = 0, checks = 0;
    rsp_t exp_q[$];
    logic [39:0] dr_q[$];

    jtag_dmi_master dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_data_i(req_data), .req_op_i(req_op),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_addr_o(rsp_addr), .rsp_data_o(rsp_data), .rsp_op_o(rsp_op),
        .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TDO(jtag_TDO)
    );

    always #5 clk = ~clk;

    // target TAP: standard state machine, DR shift register captures tdo_word
    tap_t        ts = TLR;
    logic [39:0] tdo_word = 0, dsr = 0, dr_seen = 0;
    logic [4:0]  isr = 0, ir_seen = 0;
    int          n_shift = 0, n_ir_upd = 0, n_dr_upd = 0;
    bit          tms_log[$];

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR: return m ? TLR : RTI;
            RTI: return m ? SDS : RTI;
            SDS: return m ? SIS : CDR;
            CDR: return m ? E1D : SDR;
            SDR: return m ? E1D : SDR;
            E1D: return m ? UDR : PD;
            PD:  return m ? E2D : PD;
            E2D: return m ? UDR : SDR;
            UDR: return m ? SDS : RTI;
            SIS: return m ? TLR : CIR;
            CIR: return m ? E1I : SIR;
            SIR: return m ? E1I : SIR;
            E1I: return m ? UIR : PI;
            PI:  return m ? E2I : PI;
            E2I: return m ? UIR : SIR;
            default: return m ? SDS : RTI;
        endcase
    endfunction

    always @(posedge jtag_TCK) begin
        tms_log.push_back(jtag_TMS);
        case (ts)
            CDR: dsr <= tdo_word;
            SDR: begin dsr <= {jtag_TDI, dsr[39:1]}; n_shift <= n_shift + 1; end
            CIR: isr <= 5'b00001;
            SIR: isr <= {jtag_TDI, isr[4:1]};
            UDR: begin dr_seen <= dsr; n_dr_upd <= n_dr_upd + 1; end
            UIR: begin ir_seen <= isr; n_ir_upd <= n_ir_upd + 1; end
            default: ;
        endcase
        ts <= tap_next(ts, jtag_TMS);
    end

    always @(negedge jtag_TCK) jtag_TDO <= (ts == SDR) ? dsr[0] : 1'b0;

    // protocol monitors: high phase length and TMS/TDI stability while TCK is high
    int   hi_run = 0, bad_hi = 0, bad_chg = 0, rsp_seen = 0;
    logic p_tck = 0, p_tms = 1, p_tdi = 0;
    always @(negedge clk) begin
        if (rst) hi_run = 0;
        else begin
            if (jtag_TCK) hi_run++;
            else begin
                if (p_tck && hi_run != 4) bad_hi++;
                hi_run = 0;
            end
            if (p_tck && jtag_TCK && (jtag_TMS !== p_tms || jtag_TDI !== p_tdi)) bad_chg++;
        end
        if (rsp_valid === 1'b1) rsp_seen++;
        p_tck = jtag_TCK; p_tms = jtag_TMS; p_tdi = jtag_TDI;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] tms_bits(input int base, input int n);
        logic [63:0] v = 0;
        for (int i = 0; i < n; i++) v = {v[62:0], (base + i < tms_log.size()) ? tms_log[base + i] : 1'b0};
        return v;
    endfunction

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 3000 && req_ready !== 1'b1; i++) @(negedge clk);
        check({tag, "_ready"}, req_ready, 1);
    endtask

    int sh_base, log_base, ir_base;
    task automatic do_req(input logic [5:0] a, input logic [31:0] d, input logic [1:0] o,
                          input logic [39:0] tw, input bit push);
        tdo_word = tw;
        if (push) begin
            exp_q.push_back(rsp_t'(tw));
            dr_q.push_back({a, d, o});
        end
        sh_base = n_shift; log_base = tms_log.size(); ir_base = n_ir_upd;
        req_addr = a; req_data = d; req_op = o; req_valid = 1;
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic get_rsp(input string tag, input int hold);
        int   bad = 0;
        rsp_t r;
        for (int i = 0; i < 6000 && rsp_valid !== 1'b1; i++) @(negedge clk);
        check({tag, "_valid"}, rsp_valid, 1);
        if (rsp_valid === 1'b1) begin
            r = {rsp_addr, rsp_data, rsp_op};
            repeat (hold) begin
                @(negedge clk);
                if ({rsp_addr, rsp_data, rsp_op} !== r || rsp_valid !== 1'b1 || req_ready !== 1'b0 || jtag_TCK !== 1'b0) bad++;
            end
            if (hold > 0) check({tag, "_hold"}, bad, 0);
            check({tag, "_rsp"}, r, exp_q.pop_front());
            check({tag, "_dr"}, dr_seen, dr_q.pop_front());
            rsp_ready = 1;
            @(negedge clk);
            rsp_ready = 0;
            check({tag, "_consumed"}, {rsp_valid, req_ready}, 2'b01);
        end
    endtask

    initial begin
        #2 rst = 1;
        #2;
        check("rst_jtag", {jtag_TCK, jtag_TMS, jtag_TDI, req_ready, rsp_valid}, 5'b01000);
        check("rst_fields", {rsp_addr, rsp_data, rsp_op}, 0);
        repeat (3) @(negedge clk);
        log_base = tms_log.size();
        rst = 0;
        wait_ready("tlr");
        check("tlr_count", tms_log.size() - log_base, 6);
        check("tlr_tms", tms_bits(log_base, 6), 6'b111110);
        check("tlr_tap_idle", ts, RTI);

        do_req(6'h10, 32'h1, 2'd2, 40'h10_0000_1E02, 1);
        get_rsp("req1", 0);
        check("req1_ir", ir_seen, 5'h11);
        check("req1_ir_scans", n_ir_upd - ir_base, 1);
        check("req1_shift_bits", n_shift - sh_base, 40);
        check("req1_periods", tms_log.size() - log_base, 57);

        do_req(6'h2A, 32'hDEAD_BEEF, 2'd3, 40'hC3_89AB_CDEF, 1);
        get_rsp("req2", 20);
        check("req2_no_ir", n_ir_upd - ir_base, 0);
        check("req2_hdr_tms", tms_bits(log_base, 3), 3'b100);
        check("req2_periods", tms_log.size() - log_base, 46);

        rsp_seen = 0;
        do_req(6'h15, 32'h5555_AAAA, 2'd1, 40'hFF_FFFF_FFFF, 0);
        for (int i = 0; i < 3000 && n_shift - sh_base < 17; i++) @(negedge clk);
        check("req3_reach_bit17", n_shift - sh_base, 17);
        #3 rst = 1;
        #1;
        check("midrst_jtag", {jtag_TCK, jtag_TMS, jtag_TDI, req_ready, rsp_valid}, 5'b01000);
        check("midrst_fields", {rsp_addr, rsp_data, rsp_op}, 0);
        repeat (3) @(negedge clk);
        log_base = tms_log.size();
        rst = 0;
        wait_ready("midrst");
        check("midrst_tlr_tms", tms_bits(log_base, 6), 6'b111110);
        check("midrst_no_rsp", rsp_seen, 0);

        do_req(6'h3F, 32'h0123_4567, 2'd1, 40'h5A_F0F0_0F0F, 1);
        get_rsp("req4", 0);
        check("req4_ir_rescan", n_ir_upd - ir_base, 1);
        check("req4_ir", ir_seen, 5'h11);

        check("tck_high_len", bad_hi, 0);
        check("tms_tdi_stable", bad_chg, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
